pipelined_cla_addsub: RTL
=========================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's 8-bit combinational CLA.
- Operands are split into BLOCK-bit lookahead groups, one group resolved per pipeline stage, with the group carry registered between stages.
- Adds a subtract mode, carry-in, status flags and a valid/ready handshake with back-pressure, so it can sit on a streaming datapath between producer and consumer.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits per lookahead group (= bits resolved per stage); 1 <= BLOCK <= WIDTH.
- NG, WIDTH/BLOCK (derived, localparam), number of groups = pipeline stages = latency.

Ports:
- clk, in, 1: clock, all state on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: operand beat valid.
- in_ready, out, 1: block accepts beat this cycle.
- in_a, in, WIDTH: operand A.
- in_b, in, WIDTH: operand B.
- in_cin, in, 1: carry-in; ignored when in_sub=1.
- in_sub, in, 1: 0 = A+B+cin, 1 = A−B.
- out_valid, out, 1: result beat valid.
- out_ready, in, 1: consumer accepts result.
- out_sum, out, WIDTH: result.
- out_cout, out, 1: carry-out (in sub mode: 1 = no borrow, A >= B unsigned).
- out_ovf, out, 1: signed overflow.
- out_zero, out, 1: out_sum == 0.

Behaviour:
- Reset (async assert, sync-safe deassert on clk): all stage valids 0; every data register 0. Hence out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0 during and after reset. in_ready=1 immediately after reset.
- Operand conditioning at stage 0 input: b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Per group k: g_i = a_i & b'_i, p_i = a_i ^ b'_i. Carries within the group use full lookahead, c_{i+1} = g_i | p_i·c_i expanded to two-level sum-of-products, with no ripple. Sum bit s_i = p_i ^ c_i. The group carry-out is registered and becomes the carry-in of stage k+1.
- Skew:
  - Stage k registers the resolved sum bits of groups 0..k.
  - It also carries the unresolved A/b' bits of groups k+1..NG−1 forward.
  - It carries the group carry and the carry into the MSB (c_{W−1}).
- Final stage output:
  - out_sum = all groups.
  - out_cout = c_W.
  - out_ovf = c_W ^ c_{W−1}.
  - out_zero = ~|out_sum.
  - All outputs come from registers; there is no combinational path from in_* to out_* data.
- Latency: exactly NG cycles from accept (in_valid & in_ready) to out_valid with no stall. Throughput 1 beat/cycle.
- Handshake (per-stage valid v[k], bubble-collapsing):
  - adv[NG−1] = v[NG−1] ? out_ready : 1.
  - adv[k] = !v[k] | adv[k+1].
  - in_ready = adv[0] = !v[0] | adv[1].
  - Stage k loads from k−1 when adv[k]; v[k] <= v[k−1] on load.
  - Stage data must hold stable while not advancing.
  - out_valid = v[NG−1]; outputs stable while out_valid & !out_ready (AXI-style).
- Simultaneous: the last stage draining and stage 0 accepting in the same cycle is legal; full-pipe throughput is sustained with out_ready=1.
- Full: all v=1 and out_ready=0 → in_ready=0; no beat lost or duplicated.
- Bubbles: a gap in in_valid propagates as v=0; a downstream stall compresses bubbles.
- in_sub/in_cin are sampled with the beat and travel with it (per-beat mode); mixed add/sub streams are legal.
- Reset mid-operation: all in-flight beats are discarded; no out_valid pulse after rst deasserts until a new beat has been accepted and NG cycles have elapsed.
- NG=1 case: a single registered stage with latency 1; same handshake.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only via flags.

Decomposition:
- Package pipelined_cla_pkg holds:
  - default WIDTH/BLOCK constants;
  - mode encoding constants MODE_ADD=1'b0, MODE_SUB=1'b1;
  - a function computing NG plus a legality check (WIDTH % BLOCK == 0).
- Sub-module cla_group:
  - purely combinational, parameter BLOCK;
  - inputs a, b, cin;
  - outputs sum, cout, c_msb (carry into top bit), group G/P;
  - instantiated once per stage via generate.
- The top module owns the registers, skew and handshake.

Test Plan:
- WIDTH=32,BLOCK=8; A=0xFFFFFFFF, B=0x00000001, add, cin=0 → after 4 cycles sum=0x00000000, cout=1, ovf=0, zero=1.
- A=0x7FFFFFFF, B=0x00000001, add → sum=0x80000000, cout=0, ovf=1, zero=0. Then A=0x00000005, B=0x00000007, sub → sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back 100 random beats (mixed add/sub/cin), out_ready=1 → one result per cycle, first at cycle 4, all match the reference model, in_ready stays 1.
- Random out_ready toggling (50%) with continuous in_valid → no loss or duplication, outputs stable during stall, in_ready=0 only when all 4 stages are full and out_ready=0.
- Issue 3 beats, assert rst for 1 cycle after cycle 2 → out_valid stays 0, all outputs 0. A new beat A=3,B=4 → sum=7 exactly 4 cycles after accept.
- Sweep configs (8,8), (8,1), (16,4), (64,16) with carry-chain vectors A=all-ones, B=1 and A=0x80..0, B=0x80..0 → correct sum/cout/ovf; latency equals WIDTH/BLOCK.

Source files
------------

// File: rtl/pipelined_cla_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : pipelined_cla_pkg                                         |
// | Desc   : Shared constants and configuration helpers for the        |
// |          pipelined carry-lookahead adder/subtractor.               |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package pipelined_cla_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLOCK = 8;

  // Per-beat operating mode carried on in_sub.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of lookahead groups, which is also the pipeline depth.
  function automatic int calc_ng(input int width, input int block);
    return (block > 0) ? (width / block) : 1;
  endfunction

  // A configuration is usable only when the groups tile the word exactly.
  function automatic bit cfg_legal(input int width, input int block);
    return (block >= 1) && (block <= width) && ((width % block) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_addsub_group.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cla_group                                                 |
// | Desc   : Combinational BLOCK-bit carry-lookahead group. Every       |
// |          internal carry is a flat sum of products (no ripple).     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module cla_group
  import pipelined_cla_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o,
  output logic             g_o,
  output logic             p_o
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;
  logic [BLOCK-1:0] w_gen;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // Expand c[i+1] = g_i | p_i c_i into generate terms plus a propagated carry-in term.
  always_comb begin
    logic term;
    logic acc;
    w_c    = '0;
    w_gen  = '0;
    term   = 1'b0;
    acc    = 1'b0;
    w_c[0] = cin_i;
    for (int i = 0; i < BLOCK; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = w_g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & w_p[m];
        end
        acc = acc | term;
      end
      w_gen[i] = acc;
      term = cin_i;
      for (int j = 0; j <= i; j++) begin
        term = term & w_p[j];
      end
      w_c[i+1] = acc | term;
    end
  end

  assign sum_o   = w_p ^ w_c[BLOCK-1:0];
  assign cout_o  = w_c[BLOCK];
  assign c_msb_o = w_c[BLOCK-1];
  assign g_o     = w_gen[BLOCK-1];
  assign p_o     = &w_p;

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : pipelined_cla_addsub                                      |
// | Desc   : Pipelined add/sub; one lookahead group resolved per       |
// |          stage with skewed operands and a valid/ready handshake.   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module pipelined_cla_addsub
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG = calc_ng(WIDTH, BLOCK);

  if (!cfg_legal(WIDTH, BLOCK)) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH must be a positive multiple of BLOCK");
  end

  // Stage k: x_q holds sum bits of groups 0..k and raw A bits above them;
  // b_q holds the conditioned B bits still waiting to be resolved.
  logic [NG-1:0]    v_q;
  logic [NG-1:0]    c_q;
  logic [WIDTH-1:0] x_q [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [NG-1:0]    adv;

  // Stage k may advance unless it and every stage after it is full while the consumer stalls.
  always_comb begin
    logic all_full;
    adv      = '0;
    all_full = 1'b1;
    for (int k = NG - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      adv[k]   = out_ready | ~all_full;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[NG-1];
  assign out_sum   = x_q[NG-1];
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    logic [WIDTH-1:0] w_src_x;
    logic [WIDTH-1:0] w_src_b;
    logic             w_src_c;
    logic             w_src_v;
    logic [WIDTH-1:0] w_x_d;
    logic [WIDTH-1:0] w_b_d;
    logic [BLOCK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_gg;
    logic             w_gp;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1, so the carry-in is forced high in sub mode.
      assign w_src_x = in_a;
      assign w_src_b = (in_sub == MODE_SUB) ? ~in_b : in_b;
      assign w_src_c = (in_sub == MODE_SUB) ? 1'b1 : in_cin;
      assign w_src_v = in_valid;
    end else begin : g_next
      assign w_src_x = x_q[k-1];
      assign w_src_b = b_q[k-1];
      assign w_src_c = c_q[k-1];
      assign w_src_v = v_q[k-1];
    end

    cla_group #(.BLOCK(BLOCK)) u_grp (
      .a_i     (w_src_x[k*BLOCK +: BLOCK]),
      .b_i     (w_src_b[k*BLOCK +: BLOCK]),
      .cin_i   (w_src_c),
      .sum_o   (w_sum),
      .cout_o  (w_cout),
      .c_msb_o (w_cmsb),
      .g_o     (w_gg),
      .p_o     (w_gp)
    );

    // Replace this group's operand bits with its resolved sum; clear the consumed B bits.
    always_comb begin
      w_x_d                    = w_src_x;
      w_x_d[k*BLOCK +: BLOCK]  = w_sum;
      w_b_d                    = w_src_b;
      w_b_d[k*BLOCK +: BLOCK]  = '0;
    end

    // Stage register: valid follows the handshake, data only loads with a real beat so it holds through bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        x_q[k] <= '0;
        b_q[k] <= '0;
      end else if (adv[k]) begin
        v_q[k] <= w_src_v;
        if (w_src_v) begin
          c_q[k] <= w_cout;
          x_q[k] <= w_x_d;
          b_q[k] <= w_b_d;
        end
      end
    end

    if (k == NG - 1) begin : g_flags
      // Status flags are registered alongside the final sum so outputs stay glitch-free and stall-stable.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv[k] && w_src_v) begin
          cout_q <= w_cout;
          ovf_q  <= w_cout ^ w_cmsb;
          zero_q <= ~|w_x_d;
        end
      end
    end
  end

endmodule
`default_nettype wire
